// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the serial pattern-scan controller.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  localparam logic [3:0] PAT_DEFAULT = 4'b1011;

  // Smallest hit-counter width that holds DATA_W-PAT_W+1 matches.
  function automatic int cnt_w_min(input int data_w, input int pat_w);
    return $clog2(data_w - pat_w + 2);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial overlapping detector: history shift register, fill counter,
// comparator and the registered Moore match flag.
module seq_match_core #(
  parameter int PAT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match,
  output logic             seq_detected
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  window;

  // Window includes the bit presented this cycle; a match is only legal
  // once PAT_W real bits of the current word have been seen, so zeros left
  // in the cleared history never count as data.
  assign window = {hist, bit_in};
  assign match  = enable && (window == pattern) && (fill >= FILL_W'(PAT_W - 1));

  // History/fill advance while shifting; match flag drops outside SHIFT.
  always_ff @(posedge i_clk) begin
    if (i_reset || clear) begin
      hist         <= '0;
      fill         <= '0;
      seq_detected <= 1'b0;
    end else if (enable) begin
      hist         <= window[PAT_W-2:0];
      if (fill < FILL_W'(PAT_W - 1)) fill <= fill + 1'b1;
      seq_detected <= match;
    end else begin
      seq_detected <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-bit sequencer: accepts a word, streams it MSB-first through the
// detector and reports the per-word hit count with a done pulse.
module seq_scan_ctrl #(
  parameter int               DATA_W      = 16,
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = seq_scan_pkg::PAT_DEFAULT,
  parameter int               CNT_W       = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cfg_load,
  input  logic [PAT_W-1:0]  i_cfg_pattern,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_bit,
  output logic              o_seq_detected,
  output logic [CNT_W-1:0]  o_hit_count,
  output logic              o_done,
  output logic              o_busy
);

  import seq_scan_pkg::*;

  localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  if (CNT_W < cnt_w_min(DATA_W, PAT_W)) begin : g_cnt_w_chk
    $error("seq_scan_ctrl: CNT_W too small for DATA_W/PAT_W");
  end

  state_e            state, state_nxt;
  logic [DATA_W-1:0] sreg;
  logic [BCNT_W-1:0] bit_cnt;
  logic [PAT_W-1:0]  pattern;
  logic              accept;
  logic              last_bit;
  logic              match;

  assign accept   = (state == ST_IDLE) && i_in_valid;
  assign last_bit = (state == ST_SHIFT) && (bit_cnt == BCNT_W'(DATA_W - 1));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    o_in_ready = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_bit      = 1'b0;
    case (state)
      ST_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        o_busy = 1'b1;
        o_bit  = sreg[DATA_W-1];
        if (last_bit) state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        o_busy    = 1'b1;
        o_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pattern register, word shifter, bit counter and hit counter. A config
  // load in the accept cycle lands before the first compare, so it applies
  // to the word being accepted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pattern     <= PAT_DEFAULT;
      sreg        <= '0;
      bit_cnt     <= '0;
      o_hit_count <= '0;
    end else begin
      if ((state == ST_IDLE) && i_cfg_load) pattern <= i_cfg_pattern;
      if (accept) begin
        sreg        <= i_in_data;
        bit_cnt     <= '0;
        o_hit_count <= '0;
      end else if (state == ST_SHIFT) begin
        sreg        <= {sreg[DATA_W-2:0], 1'b0};
        bit_cnt     <= bit_cnt + 1'b1;
        o_hit_count <= o_hit_count + CNT_W'(match);
      end
    end
  end

  seq_match_core #(
    .PAT_W (PAT_W)
  ) u_core (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .clear        (accept),
    .enable       (state == ST_SHIFT),
    .bit_in       (o_bit),
    .pattern      (pattern),
    .match        (match),
    .seq_detected (o_seq_detected)
  );

endmodule
